ps2_key_ctrl: RTL and testbench

Parametrised PS/2 keyboard front end and ball controller for the VGA demo path. Receives PS/2 frames with deglitching, full framing, odd-parity check and an inter-bit timeout. Tracks E0/F0 prefixes and emits one-cycle key events. Applies arrow-key releases to a bounded ball position and number/Enter releases to a two-stage colour register.

---
 rtl/ps2_key_ctrl_pkg.sv | 14 +
 rtl/ps2_key_ctrl_rx.sv | 105 ++++++++++
 rtl/ps2_key_ctrl.sv | 122 ++++++++++++
 tb/tb_ps2_key_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ps2_key_ctrl_pkg.sv
// ps2_pkg: scan codes and receive-FSM state type shared by the PS/2 keyboard path
package ps2_pkg;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_COL1  = 8'h16;
  localparam logic [7:0] SC_COL2  = 8'h1E;
  localparam logic [7:0] SC_COL3  = 8'h26;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;
endpackage

// File: rtl/ps2_key_ctrl_rx.sv
// ps2_rx: synchronises and deglitches PS/2 lines, frames bytes, flags parity/stop/timeout errors
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  rx_state_t     r_state, w_state_n;
  logic [2:0]    r_cnt, w_cnt_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n;
  logic          w_fall, w_bit, w_good;
  assign w_fall  = r_filt_d & ~r_filt;
  assign w_bit   = r_dat_sync[1];
  assign w_good  = w_bit & (^{r_shift, r_par});
  assign rx_byte = r_shift;
  // two-flop synchronisers; lines idle high
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DATA};
    end
  // filtered clock follows the synced clock only after FILTER_LEN equal samples
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_sync[1] == r_filt) r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_sync[1];
        r_fcnt <= '0;
      end else r_fcnt <= r_fcnt + 1'b1;
    end
  // frame state register
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tcnt  <= w_tcnt_n;
    end
  // frame next-state: bit sampling on filtered falls, stop-bit check, inter-bit timeout
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_tcnt_n  = (r_state == S_IDLE || w_fall) ? '0 : r_tcnt + 1'b1;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    if (r_state != S_IDLE && !w_fall && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
      w_state_n = S_IDLE;
      w_tcnt_n  = '0;
      rx_err    = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: if (!w_bit) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
        end
        S_DATA: begin
          w_shift_n = {w_bit, r_shift[7:1]};
          w_cnt_n   = r_cnt + 1'b1;
          w_state_n = (r_cnt == 3'd7) ? S_PARITY : S_DATA;
        end
        S_PARITY: begin
          w_par_n   = w_bit;
          w_state_n = S_STOP;
        end
        default: begin
          rx_valid  = w_good;
          rx_err    = ~w_good;
          w_state_n = S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 key events with E0/F0 prefixes driving a bounded ball and a two-stage colour
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int COORD_W     = 11,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480,
  parameter int STEP        = 5,
  parameter int MARGIN      = 5,
  parameter int RSCALE      = 5,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  input  logic [2:0]         radius,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [1:0]         color,
  output logic               code_valid,
  output logic [7:0]         code,
  output logic               code_break,
  output logic               code_ext,
  output logic               frame_err
);
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] L_STEP   = SW'(STEP);
  localparam logic signed [SW-1:0] L_MARGIN = SW'(MARGIN);
  localparam logic signed [SW-1:0] L_XLIM   = SW'(X_MAX - MARGIN);
  localparam logic signed [SW-1:0] L_YLIM   = SW'(Y_MAX - MARGIN);
  logic                      w_rx_valid, w_rx_err;
  logic [7:0]                w_rx_byte;
  logic                      r_ext, r_brk;
  logic                      r_valid, r_err, r_code_brk, r_code_ext;
  logic [7:0]                r_code;
  logic [COORD_W-1:0]        r_x, r_y;
  logic [1:0]                r_pend, r_color;
  logic signed [SW-1:0]      w_x, w_y, w_r;
  logic                      w_act, w_up_ok, w_dn_ok, w_lf_ok, w_rt_ok;
  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .CLK     (CLK),
    .reset   (reset),
    .PS2_CLK (PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .rx_valid(w_rx_valid),
    .rx_byte (w_rx_byte),
    .rx_err  (w_rx_err)
  );
  // prefix tracking and one-cycle event / error strobes
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= '0;
      r_code_brk <= 1'b0;
      r_code_ext <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_rx_err) begin
        r_err <= 1'b1;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_rx_valid) begin
        if (w_rx_byte == SC_E0) r_ext <= 1'b1;
        else if (w_rx_byte == SC_F0) r_brk <= 1'b1;
        else begin
          r_valid    <= 1'b1;
          r_code     <= w_rx_byte;
          r_code_brk <= r_brk;
          r_code_ext <= r_ext;
          r_ext      <= 1'b0;
          r_brk      <= 1'b0;
        end
      end
    end
  assign w_act   = r_valid & r_code_brk;
  assign w_x     = $signed(SW'(r_x));
  assign w_y     = $signed(SW'(r_y));
  assign w_r     = $signed(SW'(radius) * SW'(RSCALE));
  assign w_up_ok = (w_y - w_r - L_STEP) >= L_MARGIN;
  assign w_dn_ok = (w_y + w_r + L_STEP) <= L_YLIM;
  assign w_lf_ok = (w_x - w_r - L_STEP) >= L_MARGIN;
  assign w_rt_ok = (w_x + w_r + L_STEP) <= L_XLIM;
  // arrow releases move the ball only when the whole step stays inside the margins
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_x <= COORD_W'(X_MAX / 2);
      r_y <= COORD_W'(Y_MAX / 2);
    end else if (w_act) begin
      if (r_code == SC_UP && w_up_ok) r_y <= r_y - COORD_W'(STEP);
      if (r_code == SC_DOWN && w_dn_ok) r_y <= r_y + COORD_W'(STEP);
      if (r_code == SC_LEFT && w_lf_ok) r_x <= r_x - COORD_W'(STEP);
      if (r_code == SC_RIGHT && w_rt_ok) r_x <= r_x + COORD_W'(STEP);
    end
  // number releases choose a pending colour; Enter release commits it
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_pend  <= 2'd1;
      r_color <= 2'd1;
    end else if (w_act) begin
      r_pend  <= (r_code == SC_COL1) ? 2'd1 :
                 (r_code == SC_COL2) ? 2'd2 :
                 (r_code == SC_COL3) ? 2'd3 : r_pend;
      r_color <= (r_code == SC_ENTER) ? r_pend : r_color;
    end
  assign ball_x     = r_x;
  assign ball_y     = r_y;
  assign color      = r_color;
  assign code_valid = r_valid;
  assign code       = r_code;
  assign code_break = r_code_brk;
  assign code_ext   = r_code_ext;
  assign frame_err  = r_err;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed PS/2 frames with hand-computed ball, colour and event expectations
module tb_ps2_key_ctrl;
  localparam int H = 12;
  localparam int TO = 400;
  logic        CLK = 1'b0, reset = 1'b1, PS2_CLK = 1'b1, PS2_DATA = 1'b1;
  logic [2:0]  radius = 3'd2;
  logic [10:0] ball_x, ball_y;
  logic [1:0]  color;
  logic        code_valid, code_break, code_ext, frame_err;
  logic [7:0]  code;
  int n_checks = 0, n_errors = 0;
  int n_valid = 0, n_err = 0, l_code = 0, l_brk = 0, l_ext = 0;
  ps2_key_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .radius(radius),
    .ball_x(ball_x), .ball_y(ball_y), .color(color), .code_valid(code_valid), .code(code),
    .code_break(code_break), .code_ext(code_ext), .frame_err(frame_err)
  );
  always #5 CLK = ~CLK;
  // event recorder sampled away from the active edge
  always @(negedge CLK)
    if (!reset) begin
      if (code_valid) begin
        n_valid++;
        l_code = int'(code);
        l_brk  = int'(code_break);
        l_ext  = int'(code_ext);
      end
      if (frame_err) n_err++;
    end
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send_bit(input logic b, input bit glitch);
    PS2_DATA = b;
    if (glitch) begin
      tick(4);
      PS2_CLK = 1'b0;
      tick(2);
      PS2_CLK = 1'b1;
      tick(H - 6);
    end else tick(H);
    PS2_CLK = 1'b0;
    tick(H);
    PS2_CLK = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit stop = 1,
                            input bit glitch = 0);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ bad_par, glitch);
    send_bit(stop, glitch);
    PS2_DATA = 1'b1;
    tick(30);
  endtask
  initial begin
    tick(5);
    reset = 1'b0;
    tick(2);
    check("rst_x", int'(ball_x), 320);
    check("rst_y", int'(ball_y), 240);
    check("rst_color", int'(color), 1);
    check("rst_valid", int'(code_valid), 0);
    check("rst_code", int'(code), 0);
    check("rst_break", int'(code_break), 0);
    check("rst_ext", int'(code_ext), 0);
    check("rst_ferr", int'(frame_err), 0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("up_n", n_valid, 1);
    check("up_code", l_code, 'h75);
    check("up_brk", l_brk, 1);
    check("up_ext", l_ext, 0);
    check("up_y", int'(ball_y), 235);
    check("up_x", int'(ball_x), 320);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h74);
    check("rt_n", n_valid, 2);
    check("rt_code", l_code, 'h74);
    check("rt_ext", l_ext, 1);
    check("rt_brk", l_brk, 1);
    check("rt_x", int'(ball_x), 325);
    send_frame(8'hE0);
    send_frame(8'h74);
    check("press_n", n_valid, 3);
    check("press_brk", l_brk, 0);
    check("press_ext", l_ext, 1);
    check("press_x", int'(ball_x), 325);
    radius = 3'd7;
    for (int i = 0; i < 38; i++) begin
      send_frame(8'hF0);
      send_frame(8'h75);
    end
    check("lim_y45", int'(ball_y), 45);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("lim_y40", int'(ball_y), 40);
    send_frame(8'hF0);
    send_frame(8'h75);
    check("lim_hold", int'(ball_y), 40);
    check("lim_n", n_valid, 43);
    send_frame(8'hF0);
    send_frame(8'h26);
    check("col_pend", int'(color), 1);
    send_frame(8'hF0);
    send_frame(8'h5A);
    check("col_enter3", int'(color), 3);
    send_frame(8'hF0);
    send_frame(8'h1E);
    check("col_noenter", int'(color), 3);
    send_frame(8'hF0);
    send_frame(8'h5A);
    check("col_enter2", int'(color), 2);
    send_frame(8'hF0);
    send_frame(8'h75, 1'b1);
    check("par_err", n_err, 1);
    check("par_nvalid", n_valid, 47);
    send_frame(8'h72);
    check("clr_n", n_valid, 48);
    check("clr_brk", l_brk, 0);
    check("clr_code", l_code, 'h72);
    check("clr_y", int'(ball_y), 40);
    send_frame(8'h72, 1'b0, 1'b0);
    check("stop_err", n_err, 2);
    check("stop_nvalid", n_valid, 48);
    send_frame(8'hE0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    PS2_DATA = 1'b1;
    tick(TO + 50);
    check("to_err", n_err, 3);
    send_frame(8'hF0);
    send_frame(8'h6B);
    check("to_n", n_valid, 49);
    check("to_code", l_code, 'h6B);
    check("to_ext", l_ext, 0);
    check("to_brk", l_brk, 1);
    check("to_x", int'(ball_x), 320);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1, 1'b1);
    check("gl_n", n_valid, 50);
    check("gl_err", n_err, 3);
    check("gl_code", int'(code), 'h74);
    check("gl_x", int'(ball_x), 325);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
